// File: rtl/mem_pkg.sv
// mem_pkg: access sizes, dm lane codes and controller state encoding shared by the MEM-stage access logic
package mem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [2:0] DMOP_W   = 3'b000;
  localparam logic [2:0] DMOP_HLO = 3'b001;
  localparam logic [2:0] DMOP_HHI = 3'b010;
  localparam logic [2:0] DMOP_B0  = 3'b011;
  localparam logic [2:0] DMOP_B1  = 3'b100;
  localparam logic [2:0] DMOP_B2  = 3'b101;
  localparam logic [2:0] DMOP_B3  = 3'b110;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic [2:0] dmop_of(input logic [1:0] size, input logic [1:0] lo);
    return size == SIZE_W ? DMOP_W :
           size == SIZE_H ? (lo[1] ? DMOP_HHI : DMOP_HLO) :
           lo == 2'd0 ? DMOP_B0 : lo == 2'd1 ? DMOP_B1 : lo == 2'd2 ? DMOP_B2 : DMOP_B3;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half lane out of a dm word and sign/zero-extends it
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    result = size == SIZE_B ? {{24{~uns & b[7]}}, b} :
             size == SIZE_H ? {{16{~uns & h[15]}}, h} : word;
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store controller in front of dm_4k; checks requests, drives
// one-cycle dm accesses and returns extended load data over a valid/ready response.
module dm_access_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic [2:0]        dm_dmop,
  input  logic [31:0]       dm_dout
);
  state_t      state, state_n;
  logic [1:0]  size_q, lo_q;
  logic        uns_q, bad;
  logic [31:0] ext;
  load_extend u_ext (.word(dm_dout), .lo(lo_q), .size(size_q), .uns(uns_q), .result(ext));
  assign bad = req_size == 2'b11 || (req_size == SIZE_H && req_addr[0]) ||
               (req_size == SIZE_W && req_addr[1:0] != 2'b00) ||
               req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W];
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  always_comb begin
    state_n = state == IDLE   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? RESP : (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // dm_we lives for exactly the ACCESS cycle; dm_addr/dmop keep their last value otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= SIZE_B;
      lo_q       <= 2'b00;
      uns_q      <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      dm_we      <= 1'b0;
      dm_dmop    <= DMOP_W;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      dm_we <= 1'b0;
      if (state == IDLE && req_valid) begin
        size_q <= req_size;
        lo_q   <= req_addr[1:0];
        uns_q  <= req_uns;
        dm_din <= req_wdata;
        if (bad) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          dm_addr <= req_addr[ADDR_W-1:2];
          dm_dmop <= dmop_of(req_size, req_addr[1:0]);
          dm_we   <= req_we;
        end
      end
      if (state == ACCESS) begin
        resp_err   <= 1'b0;
        resp_rdata <= dm_we ? 32'h0 : ext;
      end
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed checks of dm_access_ctrl against a behavioural dm_4k model
module tb_dm_access_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_uns = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;
  logic        dm_we;
  logic [2:0]  dm_dmop;
  logic [31:0] mem [0:1023];
  int          checks = 0, errors = 0, we_cnt = 0;
  logic [31:0] rd;
  logic        er, w, unst;
  int          lat;
  logic [9:0]  a;
  logic [2:0]  op;

  dm_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dmop(dm_dmop), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;
  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      we_cnt <= we_cnt + 1;
      case (dm_dmop)
        3'd0: mem[dm_addr] <= dm_din;
        3'd1: mem[dm_addr][15:0] <= dm_din[15:0];
        3'd2: mem[dm_addr][31:16] <= dm_din[15:0];
        3'd3: mem[dm_addr][7:0] <= dm_din[7:0];
        3'd4: mem[dm_addr][15:8] <= dm_din[7:0];
        3'd5: mem[dm_addr][23:16] <= dm_din[7:0];
        3'd6: mem[dm_addr][31:24] <= dm_din[7:0];
        default: ;
      endcase
    end
  end

  task automatic transact(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdo, output logic ero, output int lto,
                          output logic [9:0] ao, output logic [2:0] opo, output logic wo,
                          output logic uo);
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    lto = 1; ao = 0; opo = 0; wo = 0; uo = 0;
    if (!resp_valid) begin ao = dm_addr; opo = dm_dmop; wo = dm_we; end
    while (!resp_valid && lto < 6) begin @(posedge clk); #1; lto++; end
    checks++;
    if (!resp_valid) begin errors++; $display("FAIL resp_timeout addr=%h got resp_valid=%b exp 1", addr, resp_valid); end
    rdo = resp_rdata; ero = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!resp_valid || req_ready || resp_rdata !== rdo || resp_err !== ero) uo = 1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, dm_we, dm_dmop} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 1000000", {req_ready, resp_valid, resp_err, dm_we, dm_dmop});
    end
    checks++;
    if ({resp_rdata, dm_din, dm_addr} !== 74'h0) begin
      errors++; $display("FAIL reset_data got rdata=%h din=%h addr=%h exp 0", resp_rdata, dm_din, dm_addr);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_word;
    transact(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if ({a, op, w, er} !== {10'd4, 3'b000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sw_access got addr=%0d op=%b we=%b err=%b exp 4 000 1 0", a, op, w, er);
    end
    checks++;
    if (lat !== 2 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got lat=%0d rdata=%h exp 2 0", lat, rd); end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h exp deadbeef", mem[4]); end
    transact(0, 2'b10, 0, 32'h010, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 0 || w !== 0) begin
      errors++; $display("FAIL lw_resp got rdata=%h err=%b we=%b exp deadbeef 0 0", rd, er, w);
    end
  endtask

  task automatic test_byte;
    transact(1, 2'b00, 0, 32'h013, 32'h80, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (op !== 3'b110 || mem[4] !== 32'h80ADBEEF) begin
      errors++; $display("FAIL sb_op_mem got op=%b mem=%h exp 110 80adbeef", op, mem[4]);
    end
    transact(0, 2'b00, 0, 32'h013, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rd); end
    transact(0, 2'b00, 1, 32'h013, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", rd); end
    transact(0, 2'b00, 0, 32'h011, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'hFFFFFFBE || op !== 3'b100) begin
      errors++; $display("FAIL lb1 got rdata=%h op=%b exp ffffffbe 100", rd, op);
    end
  endtask

  task automatic test_half;
    transact(1, 2'b01, 0, 32'h012, 32'h1234, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (op !== 3'b010 || mem[4] !== 32'h1234BEEF) begin
      errors++; $display("FAIL sh_op_mem got op=%b mem=%h exp 010 1234beef", op, mem[4]);
    end
    transact(0, 2'b01, 0, 32'h012, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_rdata got %h exp 00001234", rd); end
    transact(1, 2'b10, 0, 32'h020, 32'h80005555, 0, rd, er, lat, a, op, w, unst);
    transact(0, 2'b01, 0, 32'h022, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL lh_neg got %h exp ffff8000", rd); end
    transact(0, 2'b01, 1, 32'h022, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'h00008000) begin errors++; $display("FAIL lhu got %h exp 00008000", rd); end
    transact(0, 2'b01, 0, 32'h020, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'h00005555 || op !== 3'b001 || a !== 10'd8) begin
      errors++; $display("FAIL lh_lo got rdata=%h op=%b addr=%0d exp 00005555 001 8", rd, op, a);
    end
  endtask

  task automatic test_errors;
    int wc;
    wc = we_cnt;
    transact(0, 2'b10, 0, 32'h011, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (er !== 1 || lat !== 1 || rd !== 0) begin
      errors++; $display("FAIL lw_misalign got err=%b lat=%0d rdata=%h exp 1 1 0", er, lat, rd);
    end
    transact(1, 2'b01, 0, 32'h013, 32'hFFFF, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (er !== 1 || lat !== 1) begin errors++; $display("FAIL sh_misalign got err=%b lat=%0d exp 1 1", er, lat); end
    transact(1, 2'b11, 0, 32'h010, 32'hFFFF_FFFF, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (er !== 1 || lat !== 1) begin errors++; $display("FAIL size11 got err=%b lat=%0d exp 1 1", er, lat); end
    checks++;
    if (we_cnt !== wc || mem[4] !== 32'h1234BEEF) begin
      errors++; $display("FAIL err_nowrite got writes=%0d mem=%h exp 0 1234beef", we_cnt - wc, mem[4]);
    end
  endtask

  task automatic test_hold;
    transact(1, 2'b10, 0, 32'h1000, 32'h1, 5, rd, er, lat, a, op, w, unst);
    checks++;
    if (er !== 1 || lat !== 1 || rd !== 0) begin
      errors++; $display("FAIL window got err=%b lat=%0d rdata=%h exp 1 1 0", er, lat, rd);
    end
    checks++;
    if (unst !== 0) begin errors++; $display("FAIL hold_stable got unstable=%b exp 0", unst); end
    checks++;
    if (req_ready !== 1 || resp_valid !== 0) begin
      errors++; $display("FAIL hold_release got ready=%b valid=%b exp 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    transact(1, 2'b10, 0, 32'h030, 32'h11111111, 0, rd, er, lat, a, op, w, unst);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b10; req_uns = 0; req_addr = 32'h030; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if (dm_we !== 1 || dm_din !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mid_access got we=%b din=%h exp 1 cafef00d", dm_we, dm_din);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({dm_we, req_ready, resp_valid, resp_err, dm_dmop, dm_addr, dm_din, resp_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 10'd0, 64'h0}) begin
      errors++; $display("FAIL mid_reset got we=%b ready=%b valid=%b addr=%h din=%h exp 0 1 0 0 0", dm_we, req_ready, resp_valid, dm_addr, dm_din);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[12] !== 32'h11111111) begin errors++; $display("FAIL mid_mem got %h exp 11111111", mem[12]); end
    @(negedge clk); rst_n = 1;
    transact(0, 2'b10, 0, 32'h010, 32'h0, 0, rd, er, lat, a, op, w, unst);
    checks++;
    if (rd !== 32'h1234BEEF || er !== 0 || lat !== 2) begin
      errors++; $display("FAIL post_reset got rdata=%h err=%b lat=%0d exp 1234beef 0 2", rd, er, lat);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_hold;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
